// File: rtl/kmp_tabla_builder_if.sv
// kmp_tabla_builder_if: pattern-load / table-read bundle for kmp_tabla_builder.
//   master modport (upstream + searcher side): drives pat_we/pat_addr/pat_data,
//     pat_len, start, rd_addr; observes rd_pat, rd_tab, busy, done, tab_valid,
//     err, cyc_count.
//   slave modport (kmp_tabla_builder): the mirror image.
interface kmp_tabla_builder_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_PAT = 16,
    parameter int unsigned IDX_W   = $clog2(MAX_PAT),
    parameter int unsigned LEN_W   = $clog2(MAX_PAT + 1)
);
    logic              pat_we;
    logic [IDX_W-1:0]  pat_addr;
    logic [DATA_W-1:0] pat_data;
    logic [LEN_W-1:0]  pat_len;
    logic              start;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_pat;
    logic [IDX_W-1:0]  rd_tab;
    logic              busy;
    logic              done;
    logic              tab_valid;
    logic              err;
    logic [15:0]       cyc_count;

    modport master (
        output pat_we, pat_addr, pat_data, pat_len, start, rd_addr,
        input  rd_pat, rd_tab, busy, done, tab_valid, err, cyc_count
    );

    modport slave (
        input  pat_we, pat_addr, pat_data, pat_len, start, rd_addr,
        output rd_pat, rd_tab, busy, done, tab_valid, err, cyc_count
    );
endinterface

// File: rtl/kmp_tabla_builder.sv
// kmp_tabla_builder: stores a search pattern and builds its KMP failure (LPS)
// table, one symbol comparison per cycle, ahead of the KMP search controller.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - kmp_tabla_builder_if.slave: pattern write port, build start,
//          combinational pattern/table read port, busy/done/tab_valid/err
//          status, and cyc_count.
// Optional macro KMP_TABLA_CYCLES_EN: when defined, cyc_count counts busy
// cycles of the latest accepted build (saturating); otherwise it reads 0.
module kmp_tabla_builder #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_PAT = 16,
    parameter int unsigned IDX_W   = $clog2(MAX_PAT),
    parameter int unsigned LEN_W   = $clog2(MAX_PAT + 1)
) (
    input logic                clk,
    input logic                rst,
    kmp_tabla_builder_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StInit, StCompare, StAdvance, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pat_q [MAX_PAT];
    logic [DATA_W-1:0] pat_d [MAX_PAT];
    logic [IDX_W-1:0]  lps_q [MAX_PAT];
    logic [IDX_W-1:0]  lps_d [MAX_PAT];
    logic [IDX_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]  q_q, q_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              tab_valid_q, tab_valid_d;
    logic              err_q, err_d;

    logic len_bad;
    logic sym_eq;
    logic q_last;
    logic busy;

    assign len_bad = (bus.pat_len == '0) || (bus.pat_len > LEN_W'(MAX_PAT));
    assign sym_eq  = (pat_q[k_q] == pat_q[q_q]);
    assign q_last  = (LEN_W'(q_q) == len_q - LEN_W'(1));
    assign busy    = (state_q == StInit) || (state_q == StCompare) || (state_q == StAdvance);

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        lps_d       = lps_q;
        k_d         = k_q;
        q_d         = q_q;
        len_d       = len_q;
        tab_valid_d = tab_valid_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                // The write lands in the same edge as start, so a build
                // launched together with a write sees the new symbol.
                if (bus.pat_we && (32'(bus.pat_addr) < MAX_PAT)) begin
                    pat_d[bus.pat_addr] = bus.pat_data;
                    tab_valid_d         = 1'b0;
                end
                if (bus.start) begin
                    tab_valid_d = 1'b0;
                    if (len_bad) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        len_d   = bus.pat_len;
                        err_d   = 1'b0;
                        state_d = StInit;
                    end
                end
            end
            StInit: begin
                lps_d[0] = '0;
                q_d      = IDX_W'(1);
                k_d      = '0;
                state_d  = (len_q == LEN_W'(1)) ? StDone : StCompare;
            end
            StCompare: begin
                if (sym_eq) begin
                    k_d        = k_q + IDX_W'(1);
                    lps_d[q_q] = k_q + IDX_W'(1);
                    state_d    = StAdvance;
                end else if (k_q != '0) begin
                    // Fallback step: retry with the next shorter border.
                    k_d = lps_q[k_q - IDX_W'(1)];
                end else begin
                    lps_d[q_q] = '0;
                    state_d    = StAdvance;
                end
            end
            StAdvance: begin
                if (q_last) begin
                    state_d = StDone;
                end else begin
                    q_d     = q_q + IDX_W'(1);
                    state_d = StCompare;
                end
            end
            StDone: begin
                if (!err_q) begin
                    tab_valid_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            q_q         <= '0;
            len_q       <= '0;
            tab_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < int'(MAX_PAT); i++) begin
                pat_q[i] <= '0;
                lps_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            q_q         <= q_d;
            len_q       <= len_d;
            tab_valid_q <= tab_valid_d;
            err_q       <= err_d;
            pat_q       <= pat_d;
            lps_q       <= lps_d;
        end
    end

`ifdef KMP_TABLA_CYCLES_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == StIdle) && bus.start && !len_bad) begin
            cyc_d = '0;
        end else if (busy && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign bus.cyc_count = cyc_q;
`else
    assign bus.cyc_count = '0;
`endif

    assign bus.rd_pat    = pat_q[bus.rd_addr];
    assign bus.rd_tab    = lps_q[bus.rd_addr];
    assign bus.busy      = busy;
    assign bus.done      = (state_q == StDone);
    assign bus.tab_valid = tab_valid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_kmp_tabla_builder.sv
// tb_kmp_tabla_builder: directed and randomized builds of kmp_tabla_builder
// checked against a prefix-function reference model kept in the bench.
module tb_kmp_tabla_builder;

    localparam int MAX_PAT = 16;
    localparam int IDX_W   = 4;
    localparam int LEN_W   = 5;

    logic clk;
    logic rst;

    kmp_tabla_builder_if bus ();

    kmp_tabla_builder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int last_good;

    logic [7:0] pat_m [MAX_PAT];
    int         lps_m [MAX_PAT];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference prefix function; returns the number of busy cycles the
    // build should take (init + per position: fallbacks, final compare, advance).
    function automatic int model_build(input int n);
        int k;
        int cyc;
        k   = 0;
        cyc = 1;
        lps_m[0] = 0;
        for (int q = 1; q < n; q++) begin
            while (k > 0 && pat_m[k] != pat_m[q]) begin
                k = lps_m[k-1];
                cyc++;
            end
            if (pat_m[k] == pat_m[q]) k++;
            lps_m[q] = k;
            cyc += 2;
        end
        return cyc;
    endfunction

    task automatic set_pattern(input string s);
        for (int i = 0; i < s.len(); i++) pat_m[i] = s[i];
    endtask

    task automatic load_pattern(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pat_we   = 1'b1;
            bus.pat_addr = IDX_W'(i);
            bus.pat_data = pat_m[i];
            @(posedge clk); #1;
        end
        bus.pat_we = 1'b0;
    endtask

    task automatic check_table(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rd_addr = IDX_W'(i);
            #1;
            check_eq($sformatf("lps[%0d]", i), 32'(bus.rd_tab), 32'(lps_m[i]));
            check_eq($sformatf("pat[%0d]", i), 32'(bus.rd_pat), 32'(pat_m[i]));
        end
    endtask

    // fuse: last symbol written in the start cycle. inject: start + pat_we mid-build.
    task automatic run_build(input int n, input bit fuse, input bit inject);
        bit bad;
        int exp_busy;
        int cyc;
        int nbusy;
        bad = (n == 0 || n > MAX_PAT);
        if (fuse) begin
            bus.pat_we   = 1'b1;
            bus.pat_addr = IDX_W'(n - 1);
            bus.pat_data = pat_m[n-1];
        end
        bus.pat_len = LEN_W'(n);
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.pat_we = 1'b0;
        exp_busy = bad ? 0 : model_build(n);
        cyc   = 1;
        nbusy = 0;
        while (!bus.done && cyc < 300) begin
            if (bus.busy) nbusy++;
            if (inject && cyc == 4) begin
                bus.start  = 1'b0;
                bus.pat_we = 1'b0;
            end
            if (inject && cyc == 3) begin
                bus.start    = 1'b1;
                bus.pat_len  = LEN_W'(3);
                bus.pat_we   = 1'b1;
                bus.pat_addr = '0;
                bus.pat_data = ~pat_m[0];
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start  = 1'b0;
        bus.pat_we = 1'b0;
        check_eq("done_cycle", 32'(cyc), 32'(exp_busy + 1));
        check_eq("busy_cycles", 32'(nbusy), 32'(exp_busy));
`ifdef KMP_TABLA_CYCLES_EN
        if (!bad) check_eq("cyc_count", 32'(bus.cyc_count), 32'(exp_busy));
`else
        check_eq("cyc_count", 32'(bus.cyc_count), 32'd0);
`endif
        @(posedge clk); #1;
        check_eq("done_pulse_end", 32'(bus.done), 32'd0);
        check_eq("err", 32'(bus.err), 32'(bad));
        check_eq("tab_valid", 32'(bus.tab_valid), 32'(!bad));
        if (bad) begin
            check_table(last_good);
        end else begin
            last_good = n;
            check_table(n);
        end
    endtask

    initial begin
        int n;
        bit fuse;
        n_vec = 0;
        n_err = 0;
        last_good = 0;
        for (int i = 0; i < MAX_PAT; i++) begin
            pat_m[i] = '0;
            lps_m[i] = 0;
        end
        bus.pat_we   = 1'b0;
        bus.pat_addr = '0;
        bus.pat_data = '0;
        bus.pat_len  = '0;
        bus.start    = 1'b0;
        bus.rd_addr  = IDX_W'(5);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_tab_valid", 32'(bus.tab_valid), 32'd0);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("rst_cyc_count", 32'(bus.cyc_count), 32'd0);
        check_eq("rst_rd_tab", 32'(bus.rd_tab), 32'd0);
        check_eq("rst_rd_pat", 32'(bus.rd_pat), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        set_pattern("ABABAC");  load_pattern(6); run_build(6, 1'b0, 1'b0);
        set_pattern("AABAAAB"); load_pattern(7); run_build(7, 1'b0, 1'b0);
        set_pattern("AAAA");    load_pattern(4); run_build(4, 1'b0, 1'b0);
        set_pattern("Z");       load_pattern(1); run_build(1, 1'b0, 1'b0);
        run_build(0, 1'b0, 1'b0);
        run_build(17, 1'b0, 1'b0);

        // Mid-build start and write must be ignored.
        set_pattern("ABACABAB"); load_pattern(8); run_build(8, 1'b0, 1'b1);

        // Write after done invalidates the table.
        bus.pat_we   = 1'b1;
        bus.pat_addr = '0;
        bus.pat_data = pat_m[0];
        @(posedge clk); #1;
        bus.pat_we = 1'b0;
        check_eq("we_clears_valid", 32'(bus.tab_valid), 32'd0);

        // Reset in the 3rd cycle of a build.
        set_pattern("ABABAC"); load_pattern(6);
        bus.pat_len = LEN_W'(6);
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(bus.busy), 32'd0);
        check_eq("midrst_done", 32'(bus.done), 32'd0);
        check_eq("midrst_tab_valid", 32'(bus.tab_valid), 32'd0);
        for (int i = 0; i < MAX_PAT; i++) begin
            pat_m[i] = '0;
            lps_m[i] = 0;
        end
        check_table(MAX_PAT);
        @(posedge clk); #1;
        check_eq("midrst_done_hold", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("postrst_done", 32'(bus.done), 32'd0);
        last_good = 0;
        set_pattern("AABAAAB"); load_pattern(7); run_build(7, 1'b0, 1'b0);

        // Randomized builds over a small alphabet so fallbacks occur often.
        for (int t = 0; t < 25; t++) begin
            n = int'($urandom_range(1, MAX_PAT));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) pat_m[i] = 8'($urandom);
                else pat_m[i] = 8'h41 + 8'($urandom_range(0, 2));
            end
            fuse = 1'($urandom_range(0, 1));
            if (fuse) load_pattern(n - 1);
            else load_pattern(n);
            run_build(n, fuse, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kmp_tabla_builder.md
Name: kmp_tabla_builder

Overview:
Pre-processing stage placed directly upstream of the KMP search controller. It stores the search pattern, computes the KMP failure table (the prefix-function / LPS array), and exposes that table through a combinational read port. Its done pulse drives the search FSM's start/inicio input, and the searcher reads pattern and table entries during matching.

Parameters:
DATA_W, 8, width of one pattern symbol
MAX_PAT, 16, maximum pattern length in symbols
IDX_W, $clog2(MAX_PAT), width of pattern index and table entry
LEN_W, $clog2(MAX_PAT+1), width of pattern length

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
pat_we  input  1  pattern symbol write strobe
pat_addr  input  IDX_W  pattern write index
pat_data  input  DATA_W  pattern symbol
pat_len  input  LEN_W  pattern length, sampled on start
start  input  1  begin table build, single-cycle pulse
rd_addr  input  IDX_W  read index for pattern/table
rd_pat  output  DATA_W  pattern[rd_addr], combinational
rd_tab  output  IDX_W  lps[rd_addr], combinational
busy  output  1  build in progress
done  output  1  one-cycle pulse at build end
tab_valid  output  1  table matches the current pattern
err  output  1  last build rejected (bad length)
cyc_count  output  16  build cycle counter (see Optional Feature)

Behaviour:
- Reset: all FSM registers to IDLE; k, q, len_r = 0; pattern and lps arrays cleared to 0; busy=0, done=0, tab_valid=0, err=0, cyc_count=0. Reset mid-build aborts the build immediately with no done pulse.
- Pattern writes are accepted only in IDLE. pat_we in IDLE clears tab_valid in the same cycle. pat_we is ignored while busy.
- Algorithm, one comparison per cycle:
  - lps[0]=0.
  - For q=1..len-1: while k>0 and P[k]!=P[q], set k=lps[k-1]. If P[k]==P[q], set k=k+1. Then lps[q]=k.
- FSM states:
  - IDLE: busy=0. On start:
    - pat_len==0 or pat_len>MAX_PAT: go to DONE with err=1; the table is untouched and tab_valid=0.
    - Otherwise: latch len_r=pat_len, set err=0, tab_valid=0, then go to INIT.
  - INIT: lps[0]<=0, q<=1, k<=0. If len_r==1, go to DONE; otherwise go to COMPARE.
  - COMPARE: three cases, evaluated in order:
    - P[k]==P[q]: k<=k+1, lps[q]<=k+1, go to ADVANCE.
    - Else if k>0: k<=lps[k-1], stay in COMPARE (fallback step).
    - Else: lps[q]<=0, go to ADVANCE.
  - ADVANCE: if q==len_r-1, go to DONE; otherwise q<=q+1 and go to COMPARE.
  - DONE: done=1 for exactly one cycle. Set tab_valid=1 if err==0. Next state is IDLE.
- busy=1 in INIT, COMPARE and ADVANCE only.
- start while busy or in DONE is ignored.
- start and pat_we in the same IDLE cycle: the write completes first, and the build uses the written symbol.
- rd_pat and rd_tab are pure array reads; they are valid at any time, including mid-build. Reads at or beyond len_r return the stored (stale) contents.
- Latency: at most 1 + 2*(len-1) + (total fallback steps) + 1 cycles from start to done.
- Symbol comparison is full DATA_W equality, unsigned.
- k never exceeds q; all lps entries are less than len_r.

Optional Feature:
- Macro: KMP_TABLA_CYCLES_EN.
- Defined: cyc_count clears on an accepted start. It increments by 1 each cycle that busy=1 and saturates at 16'hFFFF. It holds its value after done until the next start.
- Undefined: cyc_count is tied to 0 and no counter logic is synthesised.

Test Plan:
- Write "ABABAC" (len 6), start -> done pulse, tab_valid=1, err=0; lps reads back 0,0,1,2,3,0.
- Write "AABAAAB" (len 7), start -> lps 0,1,0,1,2,2,3. The fallback at q=5 (k 2->1) is exercised.
- Write "AAAA", start with KMP_TABLA_CYCLES_EN defined -> lps 0,1,2,3; busy high for exactly 7 cycles; cyc_count=7; done arrives 8 cycles after start.
- pat_len=1 with "Z" -> lps[0]=0, done after 2 cycles. pat_len=0 -> done next cycle, err=1, tab_valid=0. pat_len=17 -> err=1.
- start and pat_we issued mid-build -> both ignored, result unchanged. pat_we after done -> tab_valid drops to 0.
- Assert rst in the 3rd cycle of a build -> busy=0 immediately, no done pulse, tab_valid=0, table reads 0. A fresh start then completes normally.
